// File: rtl/pc_ctrl.sv
// Fetch sequencer for the P5 pipelined MIPS core: drives the pc register's next value and
// write enable through boot delay, sequential fetch, D-stage redirects and misalignment halt.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned BOOT_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] pc_now,
  output logic [31:0] pc_next,
  output logic        pc_en,
  output logic [1:0]  state,
  output logic        redirect_pending,
  output logic        halted,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    StBoot = 2'b00,
    StRun  = 2'b01,
    StHold = 2'b10,
    StHalt = 2'b11
  } state_e;

  localparam logic [3:0] BootLast = 4'(BOOT_DELAY - 1);

  state_e      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pend_q, pend_d;
  logic        halted_q, halted_d;
  logic [31:0] fetch_cnt_q;
  logic [31:0] fetch_cnt_d;
  logic        misaligned;

  assign misaligned  = br_taken && (br_target[1:0] != 2'b00);
  assign fetch_cnt_d = fetch_cnt_q + {31'b0, pc_en};

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pend_d     = pend_q;
    halted_d   = halted_q;
    pc_next    = RESET_PC;
    pc_en      = 1'b0;
    case (state_q)
      StBoot: begin
        if (boot_cnt_q == BootLast) begin
          state_d = StRun;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      StRun: begin
        if (misaligned) begin
          // Halt takes priority over a concurrent stall; nothing is captured.
          pc_next  = pc_now;
          state_d  = StHalt;
          halted_d = 1'b1;
        end else begin
          pc_en   = ~stall;
          pc_next = br_taken ? br_target : pc_now + 32'd4;
          if (stall && br_taken) begin
            pend_d  = br_target;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        // The stalled D-stage instruction keeps presenting its redirect; only the latched one counts.
        pc_next = pend_q;
        pc_en   = ~stall;
        if (!stall) begin
          state_d = StRun;
        end
      end
      StHalt: begin
        pc_next = pc_now;
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StBoot;
      boot_cnt_q  <= 4'd0;
      pend_q      <= 32'd0;
      halted_q    <= 1'b0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pend_q      <= pend_d;
      halted_q    <= halted_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign state            = state_q;
  assign redirect_pending = (state_q == StHold);
  assign halted           = halted_q;
  assign fetch_cnt        = fetch_cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: a driver pushes hand-computed expectations per cycle and a
// monitor pops and compares them at the falling edge, with a behavioural pc register closing the loop.
module tb_pc_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] pc_now;
  logic [31:0] pc_next;
  logic        pc_en;
  logic [1:0]  state;
  logic        redirect_pending;
  logic        halted;
  logic [31:0] fetch_cnt;

  typedef struct {
    string       name;
    logic [31:0] pc_next;
    logic        chk_pc;
    logic        en;
    logic [1:0]  st;
    logic        pend;
    logic        halt;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sq[$];
  int          n_tests;
  int          n_fail;
  logic [31:0] ecnt;

  pc_ctrl #(
    .RESET_PC  (32'h0000_3000),
    .BOOT_DELAY(2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .pc_now          (pc_now),
    .pc_next         (pc_next),
    .pc_en           (pc_en),
    .state           (state),
    .redirect_pending(redirect_pending),
    .halted          (halted),
    .fetch_cnt       (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the pc register the controller drives.
  always @(posedge clk or negedge reset) begin
    if (!reset) pc_now <= 32'h0000_3000;
    else if (pc_en) pc_now <= pc_next;
  end

  task automatic chk(input string nm, input string fld, input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s got %h want %h", nm, fld, got, want);
    end
  endtask

  // Monitor: every falling edge, compare all queued expectations against the DUT.
  initial begin
    forever begin
      @(negedge clk);
      while (sq.size() > 0) begin
        exp_t e;
        e = sq.pop_front();
        if (e.chk_pc) chk(e.name, "pc_next", pc_next, e.pc_next);
        chk(e.name, "pc_en", {31'b0, pc_en}, {31'b0, e.en});
        chk(e.name, "state", {30'b0, state}, {30'b0, e.st});
        chk(e.name, "redirect_pending", {31'b0, redirect_pending}, {31'b0, e.pend});
        chk(e.name, "halted", {31'b0, halted}, {31'b0, e.halt});
        chk(e.name, "fetch_cnt", fetch_cnt, e.cnt);
      end
    end
  end

  task automatic drive_push(input string nm, input logic rst, input logic st, input logic br,
                            input logic [31:0] tgt, input logic [31:0] xpc, input logic xchk,
                            input logic xen, input logic [1:0] xst, input logic xpend,
                            input logic xhalt);
    exp_t e;
    reset     = rst;
    stall     = st;
    br_taken  = br;
    br_target = tgt;
    if (!rst) ecnt = 32'd0;
    e.name    = nm;
    e.pc_next = xpc;
    e.chk_pc  = xchk;
    e.en      = xen;
    e.st      = xst;
    e.pend    = xpend;
    e.halt    = xhalt;
    e.cnt     = ecnt;
    sq.push_back(e);
    if (xen) ecnt = ecnt + 32'd1;
  endtask

  task automatic vec(input string nm, input logic rst, input logic st, input logic br,
                     input logic [31:0] tgt, input logic [31:0] xpc, input logic xchk,
                     input logic xen, input logic [1:0] xst, input logic xpend,
                     input logic xhalt);
    @(posedge clk);
    #1;
    drive_push(nm, rst, st, br, tgt, xpc, xchk, xen, xst, xpend, xhalt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    ecnt      = 32'd0;
    reset     = 1'b0;
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'd0;

    // Reset state and boot delay
    vec("rst0",  0, 0, 0, 32'h0, 32'h3000, 1, 0, 2'b00, 0, 0);
    vec("rst1",  0, 1, 1, 32'h5, 32'h3000, 1, 0, 2'b00, 0, 0);
    vec("boot0", 1, 0, 0, 32'h0, 32'h3000, 1, 0, 2'b00, 0, 0);
    vec("boot1", 1, 1, 1, 32'h3, 32'h3000, 1, 0, 2'b00, 0, 0);
    vec("seq0",  1, 0, 0, 32'h0, 32'h3004, 1, 1, 2'b01, 0, 0);
    vec("seq1",  1, 0, 0, 32'h0, 32'h3008, 1, 1, 2'b01, 0, 0);
    vec("seq2",  1, 0, 0, 32'h0, 32'h300C, 1, 1, 2'b01, 0, 0);
    vec("seq3",  1, 0, 0, 32'h0, 32'h3010, 1, 1, 2'b01, 0, 0);
    // Unstalled branch, zero latency
    vec("br",    1, 0, 1, 32'h3040, 32'h3040, 1, 1, 2'b01, 0, 0);
    vec("br+4",  1, 0, 0, 32'h0, 32'h3044, 1, 1, 2'b01, 0, 0);
    // Stalled redirect across three stall cycles
    vec("hold0", 1, 1, 1, 32'h3100, 32'h3100, 1, 0, 2'b01, 0, 0);
    vec("hold1", 1, 1, 1, 32'h3200, 32'h3100, 1, 0, 2'b10, 1, 0);
    vec("hold2", 1, 1, 1, 32'h3200, 32'h3100, 1, 0, 2'b10, 1, 0);
    vec("hold3", 1, 0, 1, 32'h3200, 32'h3100, 1, 1, 2'b10, 1, 0);
    vec("hold4", 1, 0, 0, 32'h0, 32'h3104, 1, 1, 2'b01, 0, 0);
    // PC wrap through the top of the address space
    vec("wrap0", 1, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1, 2'b01, 0, 0);
    vec("wrap1", 1, 0, 0, 32'h0, 32'h0000_0000, 1, 1, 2'b01, 0, 0);
    vec("wrap2", 1, 0, 0, 32'h0, 32'h0000_0004, 1, 1, 2'b01, 0, 0);
    // Asynchronous reset in the middle of HOLD
    vec("mh0",   1, 1, 1, 32'h3100, 32'h3100, 1, 0, 2'b01, 0, 0);
    vec("mh1",   1, 1, 0, 32'h0, 32'h3100, 1, 0, 2'b10, 1, 0);
    @(posedge clk);
    #3;
    drive_push("mhrst", 0, 1, 1, 32'h3100, 32'h3000, 1, 0, 2'b00, 0, 0);
    vec("mhrst1", 0, 0, 0, 32'h0, 32'h3000, 1, 0, 2'b00, 0, 0);
    vec("reb0",  1, 0, 0, 32'h0, 32'h3000, 1, 0, 2'b00, 0, 0);
    vec("reb1",  1, 0, 0, 32'h0, 32'h3000, 1, 0, 2'b00, 0, 0);
    vec("reb2",  1, 0, 0, 32'h0, 32'h3004, 1, 1, 2'b01, 0, 0);
    vec("reb3",  1, 0, 0, 32'h0, 32'h3008, 1, 1, 2'b01, 0, 0);
    // fetch_cnt rollover: preload the counter's next value for one edge
    vec("cw0",   1, 0, 0, 32'h0, 32'h300C, 1, 1, 2'b01, 0, 0);
    force dut.fetch_cnt_d = 32'hFFFF_FFFF;
    ecnt = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.fetch_cnt_d;
    drive_push("cw1", 1, 0, 0, 32'h0, 32'h3010, 1, 1, 2'b01, 0, 0);
    vec("cw2",   1, 0, 0, 32'h0, 32'h3014, 1, 1, 2'b01, 0, 0);
    // Misaligned redirect under stall: halt wins
    vec("mis",   1, 1, 1, 32'h3102, 32'h0, 0, 0, 2'b01, 0, 0);
    for (int i = 0; i < 20; i++) begin
      vec("halt", 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
          32'h3014, 1, 0, 2'b11, 0, 1);
    end
    vec("hrst",  0, 0, 0, 32'h0, 32'h3000, 1, 0, 2'b00, 0, 0);

    @(posedge clk);
    n_tests++;
    if (sq.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d want 0", sq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
